// File: rtl/miner_pkg.sv
// Shared types and widths for the mining job scheduler and its helpers.
package miner_pkg;

  localparam int unsigned NONCE_W  = 32'd32;
  localparam int unsigned TARGET_W = 32'd64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/found_fifo.sv
// Synchronous first-word-fall-through FIFO holding found nonces.
module found_fifo #(
  parameter int WIDTH = 32'd32,
  parameter int DEPTH = 32'd4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Extra pointer bit separates the full and empty cases when indices match.
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign pop_ok_s  = pop & ~empty;
  assign push_ok_s = push & (~full | pop_ok_s);
  assign pop_data  = mem_r[rd_ptr_r[AW-1:0]];

  // Storage array; writes only, contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= push_data;
    end
  end

  // Read and write pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/nonce_scheduler.sv
// Issues the nonces of one mining job to the hash pipeline, tracks in-flight
// hashes and collects comparator hits in a result FIFO.
module nonce_scheduler
  import miner_pkg::*;
#(
  parameter int FIFO_DEPTH   = 32'd4,
  parameter int MAX_INFLIGHT = 32'd128,
  parameter int CNT_W        = 32'd8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                job_valid,
  output logic                job_ready,
  input  logic [NONCE_W-1:0]  job_start,
  input  logic [NONCE_W-1:0]  job_end,
  input  logic [TARGET_W-1:0] job_target,
  input  logic                abort,
  output logic                hash_vld,
  output logic [NONCE_W-1:0]  hash_nonce,
  input  logic                hash_ready,
  output logic [TARGET_W-1:0] cmp_target,
  input  logic                cmp_busy,
  input  logic                cmp_found,
  input  logic [NONCE_W-1:0]  cmp_nonce,
  output logic                res_valid,
  output logic [NONCE_W-1:0]  res_nonce,
  input  logic                res_ready,
  output logic                busy,
  output logic                done,
  output logic                overflow
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_INFLIGHT);

  state_t             state_r;
  logic [NONCE_W-1:0] end_r;
  logic [CNT_W-1:0]   inflight_r;
  logic [CNT_W-1:0]   inflight_nxt_s;
  logic               discard_r;
  logic               accept_s;
  logic               xfer_s;
  logic               retire_s;
  logic               push_req_s;
  logic               pop_s;
  logic               drop_s;
  logic               room_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;

  assign job_ready      = (state_r == IDLE);
  assign accept_s       = job_valid & job_ready;
  assign xfer_s         = hash_vld & hash_ready;
  // Results with nothing in flight are stale (e.g. after reset) and ignored.
  assign retire_s       = cmp_busy & (inflight_r != {CNT_W{1'b0}});
  assign push_req_s     = retire_s & cmp_found & ~discard_r;
  assign res_valid      = ~fifo_empty_s;
  assign pop_s          = res_valid & res_ready;
  assign drop_s         = push_req_s & fifo_full_s & ~pop_s;
  assign inflight_nxt_s = inflight_r + CNT_W'(xfer_s) - CNT_W'(retire_s);
  assign room_s         = (inflight_nxt_s < MAX_C);

  // Job sequencing FSM with its registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      hash_vld   <= 1'b0;
      hash_nonce <= {NONCE_W{1'b0}};
      cmp_target <= {TARGET_W{1'b0}};
      end_r      <= {NONCE_W{1'b0}};
      discard_r  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (job_valid) begin
            end_r      <= job_end;
            cmp_target <= job_target;
            hash_nonce <= job_start;
            discard_r  <= 1'b0;
            busy       <= 1'b1;
            if (job_end >= job_start) begin
              state_r  <= RUN;
              hash_vld <= 1'b1;
            end else begin
              state_r <= DONE;
              done    <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            hash_vld  <= 1'b0;
            discard_r <= 1'b1;
            state_r   <= DRAIN;
          end else if (xfer_s) begin
            // End compare precedes the increment so 0xFFFFFFFF ends cleanly.
            if (hash_nonce == end_r) begin
              hash_vld <= 1'b0;
              state_r  <= DRAIN;
            end else begin
              hash_nonce <= hash_nonce + 32'd1;
              hash_vld   <= room_s;
            end
          end else if (!hash_vld) begin
            hash_vld <= room_s;
          end
        end
        DRAIN: begin
          if (abort) begin
            discard_r <= 1'b1;
          end
          if (inflight_r == {CNT_W{1'b0}}) begin
            state_r <= DONE;
            done    <= 1'b1;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r  <= IDLE;
          hash_vld <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  // In-flight hash counter and sticky drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_r <= {CNT_W{1'b0}};
      overflow   <= 1'b0;
    end else begin
      inflight_r <= inflight_nxt_s;
      if (accept_s) begin
        overflow <= 1'b0;
      end else if (drop_s) begin
        overflow <= 1'b1;
      end
    end
  end

  found_fifo #(
    .WIDTH (NONCE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_found_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_req_s),
    .push_data (cmp_nonce),
    .pop       (pop_s),
    .pop_data  (res_nonce),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

endmodule

// File: doc/nonce_scheduler.md
Name: nonce_scheduler

Overview:
Sequences one mining job through the hash pipeline and the downstream target comparator. It accepts a job (nonce range plus 64-bit target), issues nonces one per cycle under backpressure, and tracks in-flight hashes. Found nonces reported by the comparator are collected in a small result FIFO. It sits between the host/job interface and the hash core plus comparator.

Parameters:
FIFO_DEPTH, 4, found-nonce result FIFO entries (power of 2, >=2)
MAX_INFLIGHT, 128, limit on hashes issued but not yet retired
CNT_W, 8, in-flight counter width; must satisfy 2^CNT_W > MAX_INFLIGHT

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
job_valid  in  1  job offered
job_ready  out  1  scheduler idle and can accept a job
job_start  in  32  first nonce, inclusive
job_end  in  32  last nonce, inclusive
job_target  in  64  hash target
abort  in  1  abandon the current job
hash_vld  out  1  nonce offered to the hash pipeline
hash_nonce  out  32  nonce offered
hash_ready  in  1  pipeline accepts the offered nonce
cmp_target  out  64  target driven to the comparator
cmp_busy  in  1  comparator result valid this cycle (one retired hash)
cmp_found  in  1  comparator hit; meaningful only when cmp_busy=1
cmp_nonce  in  32  nonce of the retired hash
res_valid  out  1  FIFO not empty
res_nonce  out  32  FIFO head
res_ready  in  1  pop the FIFO head
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at job completion or abort
overflow  out  1  sticky flag: a found nonce was dropped

Behaviour:
- Reset values:
  - state=IDLE; job_ready=1 (combinational from IDLE).
  - hash_vld=0, hash_nonce=0, cmp_target=0, res_valid=0, busy=0, done=0, overflow=0.
  - inflight=0; FIFO empty.
- Reset may assert at any time. All state clears asynchronously. Results arriving afterwards with inflight=0 are ignored.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - job_valid & job_ready at edge N latches start, end and target. cmp_target updates at the same edge. overflow and the discard flag clear.
  - If job_end >= job_start: go to RUN. hash_vld=1 with hash_nonce=job_start from cycle N+1.
  - If job_end < job_start (empty job): go to DONE. done=1 in cycle N+1, then IDLE. No hash is issued.
  - abort in IDLE is ignored.
- RUN:
  - A transfer occurs when hash_vld & hash_ready; inflight increments.
  - While hash_vld=1 and hash_ready=0, hash_nonce is held stable.
  - hash_vld is only raised while inflight < MAX_INFLIGHT. Once raised, it stays up until transfer (the only exception is abort).
  - On transfer with hash_nonce == end: hash_vld=0 next cycle; go to DRAIN.
  - Otherwise hash_nonce increments by one, mod 2^32. The end compare is done before the increment, so end=0xFFFFFFFF terminates correctly.
  - abort: hash_vld=0 next cycle, even mid-handshake; set discard; go to DRAIN.
- DRAIN: when inflight==0, go to DONE. abort here sets discard.
- DONE: done=1 for exactly one cycle, then IDLE.
- Retire path:
  - cmp_busy=1 with inflight>0 decrements inflight.
  - Issue and retire in the same cycle leave inflight unchanged.
  - cmp_busy with inflight==0 is ignored entirely: no decrement, no capture.
- Capture path:
  - Condition: cmp_busy & cmp_found & inflight>0 & !discard pushes cmp_nonce.
  - If the FIFO is full with no simultaneous pop: the nonce is dropped and overflow=1.
  - Push and pop together when full: both succeed; overflow is not set.
- FIFO:
  - First-word fall-through: res_valid = not empty; res_nonce = head.
  - Pop on res_valid & res_ready.
  - Contents survive job boundaries; only reset flushes it.
- cmp_target holds its value until the next job is accepted.

Decomposition:
- Shared package miner_pkg:
  - state enum {IDLE, RUN, DRAIN, DONE}.
  - NONCE_W=32, TARGET_W=64.
- One sub-module, found_fifo: synchronous FWFT FIFO with parameters WIDTH and DEPTH, and push/pop/full/empty ports.

Test Plan:
1. Job 0x100..0x103, hash_ready=1, 3-cycle pipeline model flagging nonce 0x102 -> four transfers 0x100..0x103; res_nonce=0x102; single done pulse after the fourth retire; job_ready=1 afterwards.
2. Same job with hash_ready toggling 1/0 -> hash_nonce stable while stalled; no nonce skipped or repeated; exactly 4 transfers.
3. Job 0xFFFFFFFE..0xFFFFFFFF -> exactly 2 transfers, hash_vld=0 afterwards, done; also job 0x10..0x0F -> done pulse in cycle N+1, hash_vld never 1.
4. MAX_INFLIGHT=4 with pipeline never retiring -> hash_vld drops after 4 transfers; resumes one cycle after the first cmp_busy.
5. Six founds back-to-back with res_ready=0 and FIFO_DEPTH=4 -> 4 entries held, overflow=1; raising res_ready pops them in issue order; next job clears overflow.
6. abort in RUN with 3 in flight, all found -> hash_vld=0 next cycle, nothing pushed, done after 3rd retire; rst_n low mid-RUN -> all outputs at reset values immediately.
